// File: rtl/demux_1to2_stream.sv
// rtl/demux_1to2_stream.sv - buffered 1-to-2 stream demultiplexer with per-channel output FIFOs
// Each beat is steered by in_sel into its own FIFO; channels back-pressure independently.
module demux_1to2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y0_data,
    output logic [CW-1:0]    y0_count,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [WIDTH-1:0] y1_data,
    output logic [CW-1:0]    y1_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       full;
    logic [1:0]       vld;
    logic [1:0]       rdy;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    cnt  [2];

    assign rdy = {y1_ready, y0_ready};

    // Only the registered full flags gate the input, so no combinational path from y*_ready.
    assign in_ready = ~full[in_sel];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam logic SEL = (c != 0);

        logic             push;
        logic             pop;
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] mem [DEPTH];

        assign push    = in_valid & in_ready & (in_sel == SEL);
        assign pop     = vld[c] & rdy[c];
        assign vld[c]  = (count != '0);
        assign full[c] = (count == CW'(DEPTH));
        assign cnt[c]  = count;
        // Head is forced to zero when empty so stale storage never shows after reset.
        assign head[c] = vld[c] ? mem[rd_ptr] : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
        end
    end

    assign y0_valid = vld[0];
    assign y0_data  = head[0];
    assign y0_count = cnt[0];
    assign y1_valid = vld[1];
    assign y1_data  = head[1];
    assign y1_count = cnt[1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// tb/tb_demux_1to2_stream.sv - scoreboard bench for demux_1to2_stream
module tb_demux_1to2_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       y0_valid, y1_valid;
    logic       y0_ready = 1'b0, y1_ready = 1'b0;
    logic [7:0] y0_data, y1_data;
    logic [2:0] y0_count, y1_count;

    int checks = 0;
    int errors = 0;
    bit rnd_y1 = 1'b0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    demux_1to2_stream #(.WIDTH(8), .DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_count(y0_count),
        .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_count(y1_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every popped head against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (y0_valid && y0_ready) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL y0_unexpected: got %0h expected none", y0_data);
                end else begin
                    logic [7:0] e;
                    e = exp0.pop_front();
                    if (y0_data !== e) begin
                        errors++;
                        $display("FAIL y0_data: got %0h expected %0h", y0_data, e);
                    end
                end
            end
            if (y1_valid && y1_ready) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL y1_unexpected: got %0h expected none", y1_data);
                end else begin
                    logic [7:0] e;
                    e = exp1.pop_front();
                    if (y1_data !== e) begin
                        errors++;
                        $display("FAIL y1_data: got %0h expected %0h", y1_data, e);
                    end
                end
            end
        end
    end

    // Drive one beat; returns at posedge+1 after it is accepted, leaving in_valid high.
    task automatic send(input logic [7:0] d, input logic s);
        int  n = 0;
        bit  done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        while (!done && n < 50) begin
            if (rnd_y1) y1_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (s) exp1.push_back(d);
                else   exp0.push_back(d);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp0.size() + exp1.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_y0_valid", 32'(y0_valid), 32'd0);
        check("rst_y1_valid", 32'(y1_valid), 32'd0);
        check("rst_y0_count", 32'(y0_count), 32'd0);
        check("rst_y1_count", 32'(y1_count), 32'd0);
        check("rst_y0_data",  32'(y0_data),  32'd0);
        check("rst_y1_data",  32'(y1_data),  32'd0);
        in_sel = 1'b0; #1;
        check("rst_in_ready_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1; #1;
        check("rst_in_ready_sel1", 32'(in_ready), 32'd1);

        // Interleaved beats with both consumers ready
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        send(8'hA1, 1'b0);
        check("lat_y0_valid", 32'(y0_valid), 32'd1);
        check("lat_y0_data",  32'(y0_data),  32'hA1);
        send(8'hB2, 1'b1);
        check("lat_y1_valid", 32'(y1_valid), 32'd1);
        check("lat_y1_data",  32'(y1_data),  32'hB2);
        check("lat_y0_empty", 32'(y0_valid), 32'd0);
        send(8'hA3, 1'b0);
        check("lat_y0_data2", 32'(y0_data),  32'hA3);
        idle(1);
        wait_drain();

        // Fill channel 0 while stalled
        y0_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
        in_data = 8'h14;
        in_sel  = 1'b0;
        #1;
        check("full_count",    32'(y0_count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("full_hold_count", 32'(y0_count), 32'd4);
        in_sel = 1'b1;
        #1;
        check("other_ch_ready", 32'(in_ready), 32'd1);
        send(8'h14, 1'b1);

        // Full channel pops while input waits: no same-cycle push
        in_data  = 8'h15;
        in_sel   = 1'b0;
        y0_ready = 1'b1;
        #1;
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        y0_ready = 1'b0;
        check("after_pop_count", 32'(y0_count), 32'd3);
        check("after_pop_ready", 32'(in_ready), 32'd1);
        send(8'h15, 1'b0);
        check("refill_count", 32'(y0_count), 32'd4);
        idle(1);
        y0_ready = 1'b1;
        wait_drain();

        // Simultaneous push and pop on channel 1 at count 2
        y1_ready = 1'b0;
        send(8'hC1, 1'b1);
        send(8'hC2, 1'b1);
        check("pp_count_pre", 32'(y1_count), 32'd2);
        y1_ready = 1'b1;
        send(8'hC3, 1'b1);
        check("pp_count_post", 32'(y1_count), 32'd2);
        y1_ready = 1'b0;
        idle(1);
        check("pp_count_hold", 32'(y1_count), 32'd2);
        check("pp_head",       32'(y1_data),  32'hC2);
        y1_ready = 1'b1;
        wait_drain();

        // Pointer wrap on channel 1 with random consumer stalls
        rnd_y1 = 1'b1;
        for (int i = 0; i < 12; i++) send(8'(8'h60 + i), 1'b1);
        rnd_y1   = 1'b0;
        y1_ready = 1'b1;
        idle(1);
        wait_drain();
        check("end_y0_count", 32'(y0_count), 32'd0);
        check("end_y1_count", 32'(y1_count), 32'd0);

        // Reset mid-burst discards buffered beats asynchronously
        y0_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 1'b0);
        idle(1);
        check("pre_rst_count", 32'(y0_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(y0_count), 32'd0);
        check("async_rst_valid", 32'(y0_valid), 32'd0);
        exp0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_sel = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_data",  32'(y0_data),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
